fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Write-side scheduler for the async FIFO in the w_clk domain. Shares the single
//  FIFO write port between two requesters (req0: multi-byte word, e.g. ALU result;
//  req1: single-byte word, e.g. register-file read data). Round-robin grant; the
//  granted word is latched and serialised LSB-byte first into w_data/winc,
//  stalling on wfull. One clock (w_clk); reset wrst_n is asynchronous, active-low.
// PARAMETERS
//  DATA_WIDTH  8  FIFO word width, bits per byte slot written
//  BYTES0      2  byte slots per req0 word (1..4)
//  BYTES1      1  byte slots per req1 word (1..4)
// PORTS
//  w_clk       in   1                   write-domain clock
//  wrst_n      in   1                   async active-low reset
//  req0_valid  in   1                   req0 word available; held until req0_ready
//  req0_data   in   BYTES0*DATA_WIDTH   req0 word, stable while req0_valid
//  req0_ready  out  1                   1-cycle accept strobe for req0
//  req1_valid  in   1                   req1 word available; held until req1_ready
//  req1_data   in   BYTES1*DATA_WIDTH   req1 word
//  req1_ready  out  1                   1-cycle accept strobe for req1
//  wfull       in   1                   FIFO full flag (write domain)
//  w_data      out  DATA_WIDTH          byte to FIFO
//  winc        out  1                   FIFO write request
//  busy        out  1                   1 while a word is being serialised
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=1 (req0 wins first tie), byte_cnt=0, hold
//    register=0; outputs req0_ready=req1_ready=0, winc=0, w_data=0, busy=0.
//  - States: IDLE, WRITE.
//  - IDLE: if exactly one valid, grant it; if both, grant the one != last_grant.
//    Grant cycle: ready of granted requester =1 (combinational, only in IDLE),
//    data latched into hold register zero-extended to 4*DATA_WIDTH, nbytes =
//    BYTES0/BYTES1, byte_cnt=0, last_grant updated, -> WRITE next edge.
//    Never both readys in one cycle; no grant outside IDLE.
//  - WRITE: w_data = hold[byte_cnt*DATA_WIDTH +: DATA_WIDTH] (combinational from
//    registers); winc = !wfull. Byte commits on an edge with winc=1: byte_cnt+1;
//    if byte_cnt==nbytes-1 -> IDLE. wfull=1: winc=0, byte_cnt/w_data held.
//  - busy = (state==WRITE). In IDLE w_data=0, winc=0.
//  - Latency: valid seen in IDLE at cycle 0 -> first winc cycle 1 (if !wfull);
//    an N-byte word with no stalls takes N+1 cycles; back-to-back words leave one
//    IDLE (grant) cycle between them.
//  - winc never asserted with wfull=1; FIFO-side gating remains harmless.
//  - Valid dropping without ready: ignored (no grant, no state change).
//  - Reset mid-WRITE: winc drops immediately (async); remaining bytes of the
//    word are discarded; requester is not re-acked.
//  - byte_cnt width 2 bits; never exceeds nbytes-1.
// TESTING
//  1. req0_valid=1, req0_data=16'hA55A, wfull=0 -> req0_ready cycle 0; winc
//     cycles 1,2 with w_data 8'h5A then 8'hA5; busy 1..2; IDLE cycle 3.
//  2. req0/req1 both valid from reset (req1_data=8'h3C) -> req0 granted first
//     (2 bytes), req1 granted in next IDLE, 8'h3C written; then alternate.
//  3. req0 word 16'h1234 with wfull=1 on cycles 2..5 -> 8'h34 at cycle 1,
//     winc=0 cycles 2..5 with w_data=8'h12 held, 8'h12 written cycle 6.
//  4. wrst_n low during cycle 1 of a req0 word -> winc=0, busy=0 asynchronously;
//     after release with no valid, no writes occur.
//  5. req1 continuously valid, req0 raised mid-stream -> req0 granted at the
//     next IDLE; no starvation; byte stream order matches grant order exactly.
//  6. Scoreboard: 200 random valid/wfull cycles -> each accepted word appears
//     once, contiguous, LSB first; winc&&wfull never true.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two write requesters,
// the write arbiter and the async FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BYTES0     = 2,
  parameter int BYTES1     = 1
) ();
  logic                         req0_valid;
  logic [BYTES0*DATA_WIDTH-1:0] req0_data;
  logic                         req0_ready;
  logic                         req1_valid;
  logic [BYTES1*DATA_WIDTH-1:0] req1_data;
  logic                         req1_ready;
  logic                         wfull;
  logic [DATA_WIDTH-1:0]        w_data;
  logic                         winc;
  logic                         busy;

  modport master (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  wfull,
    output req0_ready, req1_ready,
    output w_data, winc, busy
  );

  modport slave (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output wfull,
    input  req0_ready, req1_ready,
    input  w_data, winc, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler for the async FIFO:
// latches one requester word and emits it LSB byte first.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BYTES0     = 2,
  parameter int BYTES1     = 1
) (
  input  logic                w_clk,
  input  logic                wrst_n,
  fifo_wr_arbiter_if.master   bus
);

  localparam int HW = 4 * DATA_WIDTH;
  localparam logic [1:0] LAST0 = 2'(BYTES0 - 1);
  localparam logic [1:0] LAST1 = 2'(BYTES1 - 1);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      nidx_q, nidx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            gnt0, gnt1;
  logic            wr;

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      nidx_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      nidx_q  <= nidx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    nidx_d         = nidx_q;
    hold_d         = hold_q;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    wr             = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.w_data     = '0;
    bus.winc       = 1'b0;
    bus.busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_q=1 means req1 went last, so req0 wins a tie
        gnt0 = bus.req0_valid
             && (!bus.req1_valid || last_q);
        gnt1 = bus.req1_valid
             && (!bus.req0_valid || !last_q);
        unique case (1'b1)
          gnt0: begin
            hold_d  = HW'(bus.req0_data);
            nidx_d  = LAST0;
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = WRITE;
          end
          gnt1: begin
            hold_d  = HW'(bus.req1_data);
            nidx_d  = LAST1;
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = WRITE;
          end
          default: ;
        endcase
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
      end
      WRITE: begin
        wr         = !bus.wfull;
        bus.busy   = 1'b1;
        bus.winc   = wr;
        bus.w_data =
          hold_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
        if (wr) begin
          if (cnt_q == nidx_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed vectors
// plus a random valid/wfull phase with a byte-queue monitor.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int B0 = 2;
  localparam int B1 = 1;

  logic w_clk;
  logic wrst_n;

  fifo_wr_arbiter_if #(
    .DATA_WIDTH(DW), .BYTES0(B0), .BYTES1(B1)
  ) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .BYTES0(B0), .BYTES1(B1)
  ) dut (
    .w_clk  (w_clk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int        n_chk = 0;
  int        n_pass = 0;
  int        nwr = 0;
  bit        auto_m = 1'b0;
  bit        acc0 = 1'b0;
  bit        acc1 = 1'b0;
  logic [7:0] sb[$];

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endfunction

  // Monitor: samples well after inputs settle each cycle
  always @(negedge w_clk) begin
    logic [7:0] e;
    #3;
    if (bus.req0_ready || bus.req1_ready)
      chk("one_ready",
          32'(bus.req0_ready & bus.req1_ready), 0);
    if (bus.req0_ready)
      chk("r0_needs_valid", 32'(bus.req0_valid), 1);
    if (bus.req1_ready)
      chk("r1_needs_valid", 32'(bus.req1_valid), 1);
    if (bus.winc) begin
      nwr++;
      chk("winc_vs_wfull", 32'(bus.wfull), 0);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL wbyte: got %h expected none",
                 bus.w_data);
      end else begin
        e = sb.pop_front();
        chk("wbyte", 32'(bus.w_data), 32'(e));
      end
    end
    if (auto_m && bus.req0_ready && bus.req0_valid) begin
      for (int k = 0; k < B0; k++)
        sb.push_back(bus.req0_data[k*DW +: DW]);
      acc0 = 1'b1;
    end
    if (auto_m && bus.req1_ready && bus.req1_valid) begin
      for (int k = 0; k < B1; k++)
        sb.push_back(bus.req1_data[k*DW +: DW]);
      acc1 = 1'b1;
    end
  end

  task automatic tick();
    @(negedge w_clk);
  endtask

  task automatic idle_chk(string nm);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
    chk({nm, "_winc"}, 32'(bus.winc), 0);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.wfull      = 1'b0;
    sb.delete();
    tick();
    tick();
    #1;
    chk("rst_r0", 32'(bus.req0_ready), 0);
    chk("rst_r1", 32'(bus.req1_ready), 0);
    chk("rst_wdata", 32'(bus.w_data), 0);
    idle_chk("rst");
    tick();
    wrst_n = 1'b1;
  endtask

  int nwr0;

  initial begin
    wrst_n = 1'b0;
    do_reset();

    // 1: single req0 word, no stalls
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 16'hA55A;
    sb.push_back(8'h5A);
    sb.push_back(8'hA5);
    #1;
    chk("t1_c0_r0", 32'(bus.req0_ready), 1);
    chk("t1_c0_r1", 32'(bus.req1_ready), 0);
    idle_chk("t1_c0");
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_c1_busy", 32'(bus.busy), 1);
    chk("t1_c1_winc", 32'(bus.winc), 1);
    chk("t1_c1_wd", 32'(bus.w_data), 32'h5A);
    tick();
    #1;
    chk("t1_c2_winc", 32'(bus.winc), 1);
    chk("t1_c2_wd", 32'(bus.w_data), 32'hA5);
    tick();
    #1;
    idle_chk("t1_c3");
    chk("t1_c3_wd", 32'(bus.w_data), 0);

    // 2: both valid from reset, alternation
    do_reset();
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 16'hBEEF;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h3C;
    sb.push_back(8'hEF);
    sb.push_back(8'hBE);
    #1;
    chk("t2_c0_r0", 32'(bus.req0_ready), 1);
    chk("t2_c0_r1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t2_c1_r1", 32'(bus.req1_ready), 0);
    tick();
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 16'h7788;
    sb.push_back(8'h3C);
    #1;
    chk("t2_c3_r1", 32'(bus.req1_ready), 1);
    chk("t2_c3_r0", 32'(bus.req0_ready), 0);
    tick();
    bus.req1_data = 8'h99;
    #1;
    chk("t2_c4_wd", 32'(bus.w_data), 32'h3C);
    tick();
    sb.push_back(8'h88);
    sb.push_back(8'h77);
    #1;
    chk("t2_c5_r0", 32'(bus.req0_ready), 1);
    chk("t2_c5_r1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    sb.push_back(8'h99);
    #1;
    chk("t2_c8_r1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    #1;
    idle_chk("t2_c10");
    chk("t2_drained", 32'(sb.size()), 0);

    // 3: wfull stall holds the second byte
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 16'h1234;
    sb.push_back(8'h34);
    sb.push_back(8'h12);
    #1;
    chk("t3_c0_r0", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t3_c1_wd", 32'(bus.w_data), 32'h34);
    for (int c = 2; c <= 5; c++) begin
      tick();
      bus.wfull = 1'b1;
      #1;
      chk("t3_stall_winc", 32'(bus.winc), 0);
      chk("t3_stall_wd", 32'(bus.w_data), 32'h12);
      chk("t3_stall_busy", 32'(bus.busy), 1);
    end
    tick();
    bus.wfull = 1'b0;
    #1;
    chk("t3_c6_winc", 32'(bus.winc), 1);
    chk("t3_c6_wd", 32'(bus.w_data), 32'h12);
    tick();
    #1;
    idle_chk("t3_c7");

    // 4: async reset mid-word discards the rest
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 16'hCAFE;
    sb.push_back(8'hFE);
    sb.push_back(8'hCA);
    #1;
    chk("t4_c0_r0", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t4_c1_winc", 32'(bus.winc), 1);
    wrst_n = 1'b0;
    #1;
    chk("t4_arst_winc", 32'(bus.winc), 0);
    chk("t4_arst_busy", 32'(bus.busy), 0);
    sb.delete();
    nwr0 = nwr;
    tick();
    tick();
    wrst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    #1;
    chk("t4_no_writes", 32'(nwr), 32'(nwr0));
    idle_chk("t4_after");

    // 5: req1 streaming, req0 raised mid-stream
    tick();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h11;
    sb.push_back(8'h11);
    #1;
    chk("t5_c0_r1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_data = 8'h22;
    tick();
    sb.push_back(8'h22);
    #1;
    chk("t5_c2_r1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_data  = 8'h33;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 16'h5566;
    tick();
    sb.push_back(8'h66);
    sb.push_back(8'h55);
    #1;
    chk("t5_c4_r0", 32'(bus.req0_ready), 1);
    chk("t5_c4_r1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    sb.push_back(8'h33);
    #1;
    chk("t5_c7_r1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    #1;
    idle_chk("t5_c9");
    chk("t5_drained", 32'(sb.size()), 0);

    // 6: random valid/wfull traffic, monitor-driven queue
    auto_m = 1'b1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (acc0) begin
        bus.req0_valid = 1'b0;
        acc0 = 1'b0;
      end
      if (acc1) begin
        bus.req1_valid = 1'b0;
        acc1 = 1'b0;
      end
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = 16'($urandom);
      end
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'($urandom);
      end
      bus.wfull = ($urandom_range(0, 3) == 0);
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.wfull      = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      #1;
      if (!bus.busy && sb.size() == 0) break;
    end
    #1;
    chk("t6_drained", 32'(sb.size()), 0);
    idle_chk("t6_end");
    auto_m = 1'b0;

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
